// File: rtl/payload_engine_ctrl_if.sv
// Byte stream, engine-bank and result signals of the payload engine sequencer.
// slave is the sequencer's view, master is the surrounding environment's.
interface payload_engine_ctrl_if #(
    parameter int NUM_ENGINES = 32,
    parameter int CNT_W       = 16
);
    logic [7:0]             s_tdata;
    logic                   s_tvalid;
    logic                   s_tlast;
    logic                   s_tready;
    logic [7:0]             char_data;
    logic                   en;
    logic                   sod;
    logic [NUM_ENGINES-1:0] eng_match;
    logic                   m_valid;
    logic                   m_ready;
    logic [NUM_ENGINES-1:0] m_match;
    logic [CNT_W-1:0]       m_bytes;
    logic                   m_trunc;

    modport master (
        output s_tdata, s_tvalid, s_tlast, eng_match, m_ready,
        input  s_tready, char_data, en, sod,
        input  m_valid, m_match, m_bytes, m_trunc
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, eng_match, m_ready,
        output s_tready, char_data, en, sod,
        output m_valid, m_match, m_bytes, m_trunc
    );
endinterface

// File: rtl/payload_engine_ctrl.sv
// Feeds one packet at a time into a regex engine bank: clear, stream,
// wait for the engine pipeline to drain, then report the match vector.
module payload_engine_ctrl #(
    parameter int NUM_ENGINES  = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int MAX_BYTES    = 1500,
    parameter int CNT_W        = 16
) (
    input logic clk,
    input logic rst,
    payload_engine_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_BYTES);
    localparam logic [3:0]       DRAIN_C = 4'(DRAIN_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [3:0]       drain_cnt;
    logic             trunc;
    logic             accept;
    logic             drain_done;

    assign accept     = bus.s_tvalid && bus.s_tready;
    assign drain_done = (drain_cnt == DRAIN_C);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.s_tready = 1'b0;
        bus.sod      = 1'b0;
        bus.m_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.s_tvalid) state_nxt = CLEAR;
            end
            CLEAR: begin
                bus.sod   = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                bus.s_tready = 1'b1;
                if (bus.s_tvalid && bus.s_tlast) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_nxt = REPORT;
            end
            REPORT: begin
                bus.m_valid = 1'b1;
                if (bus.m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // drain_cnt is 0 in the final byte's en cycle, so the sample lands
    // DRAIN_CYCLES cycles after the last en.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.char_data <= '0;
            bus.en        <= 1'b0;
            bus.m_match   <= '0;
            bus.m_bytes   <= '0;
            bus.m_trunc   <= 1'b0;
            byte_cnt      <= '0;
            drain_cnt     <= '0;
            trunc         <= 1'b0;
        end else begin
            bus.en <= accept && (byte_cnt < MAX_C);
            if (accept) bus.char_data <= bus.s_tdata;

            if (state == CLEAR) begin
                byte_cnt <= '0;
                trunc    <= 1'b0;
            end else if (accept) begin
                if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt >= MAX_C) trunc <= 1'b1;
            end

            if (state != DRAIN)   drain_cnt <= '0;
            else if (!drain_done) drain_cnt <= drain_cnt + 1'b1;

            if (state == DRAIN && drain_done) begin
                bus.m_match <= bus.eng_match;
                bus.m_bytes <= byte_cnt;
                bus.m_trunc <= trunc;
            end
        end
    end
endmodule
